uart_rx_frame_chk: RTL and testbench
====================================

// Module: uart_rx_frame_chk
// PURPOSE
//  Parametrised frame checker for the UART RX path: parity (even/odd, optional) plus 1 or 2 stop bits.
//  Driven by the RX FSM enables and the oversampling edge counter; consumes sampled_bit from the data sampler.
//  Per-frame error flags, a frame-valid strobe, sticky status and saturating error counters.
// PARAMETERS
//  DATA_W    8  payload width; parity is computed over all DATA_W bits of P_DATA
//  EDGE_W    6  width of Prescale and edge_cnt; supports Prescale 4..2**EDGE_W-1 (8/16/32 in practice)
//  ERR_CNT_W 8  width of each saturating error counter
// PORTS
//  CLK          in   1          clock
//  RST          in   1          asynchronous, active-low reset
//  Prescale     in   EDGE_W     oversampling ratio
//  edge_cnt     in   EDGE_W     oversample edge counter, 0..Prescale-1 within each bit
//  frame_start  in   1          1-cycle pulse: start bit accepted
//  par_en       in   1          parity bit present in frame
//  par_typ      in   1          0 even, 1 odd
//  stop2        in   1          1 = two stop bits
//  par_chk_en   in   1          RX FSM is in parity bit
//  stp_chk_en   in   1          RX FSM is in stop window (one or two bits)
//  sampled_bit  in   1          majority-sampled line value
//  P_DATA       in   DATA_W     deserialised payload, stable from parity/stop window to DONE
//  err_clr      in   1          clears sticky flags and counters
//  par_err      out  1          parity error, current/last frame
//  stp_err      out  1          stop error (either stop bit), current/last frame
//  frame_vld    out  1          1-cycle pulse: frame ended with no errors
//  par_err_stk  out  1          sticky parity error
//  stp_err_stk  out  1          sticky stop error
//  par_err_cnt  out  ERR_CNT_W  saturating count of frames with parity error
//  stp_err_cnt  out  ERR_CNT_W  saturating count of frames with stop error
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE.
//  chk_pt = (edge_cnt == Prescale-2); bit_end = (edge_cnt == Prescale-1); both computed in EDGE_W bits.
//  FSM: IDLE, WAIT, PAR, STP1, STP2, DONE.
//   IDLE: frame_start -> WAIT; clears par_err, stp_err.
//   WAIT: par_chk_en & par_en -> PAR; else stp_chk_en -> STP1.
//   PAR : at chk_pt, par_err <= sampled_bit != (^P_DATA ^ par_typ); stp_chk_en -> STP1.
//   STP1: at chk_pt, stp_err <= stp_err | ~sampled_bit; at bit_end -> STP2 if stop2, else DONE.
//   STP2: same check as STP1; at bit_end -> DONE.
//   DONE: one cycle; frame_vld = ~par_err & ~stp_err; counters/sticky updated from flags; -> IDLE.
//  par_err and stp_err hold until the next frame_start; they are registered (valid the cycle after chk_pt).
//  par_en=0: the parity check is skipped and par_err stays 0.
//  frame_start while not IDLE: abort the current frame, clear flags, -> WAIT; no counter/strobe update.
//  Enable dropped mid-window (stp_chk_en=0 in STP1/STP2): -> IDLE, no DONE (RX FSM abort).
//  Counters saturate at all-ones; err_clr has priority over a same-cycle DONE increment.
//  par_typ, stop2, par_en are sampled at frame_start and held for the frame.
// STRUCTURE
//  Shared package: FSM state encoding, PAR_EVEN/PAR_ODD constants.
//  One sub-module: uart_sat_cnt (ERR_CNT_W saturating counter with inc/clr), instanced twice.
// TESTING
//  Prescale=8, P_DATA=8'hA5, even, parity=0, stop=1 -> frame_vld pulse, no errors, counters unchanged.
//  Same frame, parity bit=1 -> par_err=1 from chk_pt+1, frame_vld=0, par_err_cnt=1, par_err_stk=1.
//  stop2=1, 2nd stop sampled 0 -> stp_err=1 after 2nd chk_pt, stp_err_cnt=1; 1st stop alone 0 -> also flagged.
//  Prescale=16/32, sampled_bit glitches low outside edge_cnt=Prescale-2 -> no error.
//  255 bad-stop frames + 1 more -> stp_err_cnt stays 8'hFF; err_clr in DONE cycle -> counters 0.
//  frame_start during STP1, then RST low mid-frame -> flags clear, no counter change, outputs 0.

Source files
------------

// File: rtl/uart_rx_frame_chk_pkg.sv
// rtl/uart_rx_frame_chk_pkg.sv - shared state encoding and parity constants for the RX frame checker
package uart_rx_frame_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PAR  = 3'd2,
    ST_STP1 = 3'd3,
    ST_STP2 = 3'd4,
    ST_DONE = 3'd5
  } chk_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_sat_cnt.sv
// rtl/uart_sat_cnt.sv - saturating event counter with synchronous clear
module uart_sat_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_chk.sv
// rtl/uart_rx_frame_chk.sv - UART RX parity/stop frame checker with sticky status and error counters
module uart_rx_frame_chk
  import uart_rx_frame_chk_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int EDGE_W    = 6,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [EDGE_W-1:0]    Prescale,
  input  logic [EDGE_W-1:0]    edge_cnt,
  input  logic                 frame_start,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic                 stop2,
  input  logic                 par_chk_en,
  input  logic                 stp_chk_en,
  input  logic                 sampled_bit,
  input  logic [DATA_W-1:0]    P_DATA,
  input  logic                 err_clr,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 frame_vld,
  output logic                 par_err_stk,
  output logic                 stp_err_stk,
  output logic [ERR_CNT_W-1:0] par_err_cnt,
  output logic [ERR_CNT_W-1:0] stp_err_cnt
);

  chk_state_t state_q, state_d;
  logic       par_err_q, par_err_d;
  logic       stp_err_q, stp_err_d;
  logic       par_en_q, par_typ_q, stop2_q;
  logic       done;
  logic       chk_pt, bit_end, par_exp;

  assign chk_pt  = (edge_cnt == (Prescale - EDGE_W'(2)));
  assign bit_end = (edge_cnt == (Prescale - EDGE_W'(1)));
  assign par_exp = (^P_DATA) ^ (par_typ_q == PAR_ODD);

  // Line configuration is latched per frame so mid-frame register writes cannot corrupt a check.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= 1'b0;
    end else if (frame_start) begin
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
      stop2_q   <= stop2;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    done      = 1'b0;
    if (frame_start) begin
      // A new start bit always wins, including over DONE: the old frame is abandoned unreported.
      state_d   = ST_WAIT;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          if (par_chk_en && par_en_q) begin
            state_d = ST_PAR;
          end else if (stp_chk_en) begin
            state_d = ST_STP1;
          end
        end
        ST_PAR: begin
          if (chk_pt) begin
            par_err_d = (sampled_bit != par_exp);
          end
          if (stp_chk_en) begin
            state_d = ST_STP1;
          end
        end
        ST_STP1, ST_STP2: begin
          if (!stp_chk_en) begin
            state_d = ST_IDLE;
          end else begin
            if (chk_pt) begin
              stp_err_d = stp_err_q | ~sampled_bit;
            end
            if (bit_end) begin
              state_d = ((state_q == ST_STP1) && stop2_q) ? ST_STP2 : ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign par_err   = par_err_q;
  assign stp_err   = stp_err_q;
  assign frame_vld = done & ~par_err_q & ~stp_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_stk <= 1'b0;
      stp_err_stk <= 1'b0;
    end else if (err_clr) begin
      par_err_stk <= 1'b0;
      stp_err_stk <= 1'b0;
    end else if (done) begin
      par_err_stk <= par_err_stk | par_err_q;
      stp_err_stk <= stp_err_stk | stp_err_q;
    end
  end

  uart_sat_cnt #(.W(ERR_CNT_W)) u_par_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (err_clr),
    .inc (done & par_err_q),
    .cnt (par_err_cnt)
  );

  uart_sat_cnt #(.W(ERR_CNT_W)) u_stp_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (err_clr),
    .inc (done & stp_err_q),
    .cnt (stp_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// tb/tb_uart_rx_frame_chk.sv - scoreboard bench for the UART RX frame checker
module tb_uart_rx_frame_chk;

  localparam int DATA_W    = 8;
  localparam int EDGE_W    = 6;
  localparam int ERR_CNT_W = 8;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [EDGE_W-1:0]    Prescale;
  logic [EDGE_W-1:0]    edge_cnt;
  logic                 frame_start, par_en, par_typ, stop2;
  logic                 par_chk_en, stp_chk_en, sampled_bit, err_clr;
  logic [DATA_W-1:0]    P_DATA;
  logic                 par_err, stp_err, frame_vld, par_err_stk, stp_err_stk;
  logic [ERR_CNT_W-1:0] par_err_cnt, stp_err_cnt;

  uart_rx_frame_chk #(.DATA_W(DATA_W), .EDGE_W(EDGE_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .CLK(CLK), .RST(RST), .Prescale(Prescale), .edge_cnt(edge_cnt),
    .frame_start(frame_start), .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .sampled_bit(sampled_bit),
    .P_DATA(P_DATA), .err_clr(err_clr), .par_err(par_err), .stp_err(stp_err),
    .frame_vld(frame_vld), .par_err_stk(par_err_stk), .stp_err_stk(stp_err_stk),
    .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic vld;
    logic pe;
    logic se;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_pcnt = 0;
  int   m_scnt = 0;
  logic m_pstk = 1'b0;
  logic m_sstk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in;
    frame_start = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    sampled_bit = 1'b1;
    edge_cnt    = '0;
    err_clr     = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pcnt"}, 32'(par_err_cnt), 32'(m_pcnt));
    chk({tag, "_scnt"}, 32'(stp_err_cnt), 32'(m_scnt));
    chk({tag, "_pstk"}, 32'(par_err_stk), 32'(m_pstk));
    chk({tag, "_sstk"}, 32'(stp_err_stk), 32'(m_sstk));
  endtask

  // One bit window of n oversample edges; the flag is checked right after the chk_pt edge.
  task automatic one_bit(input int ps, input int n, input logic is_par, input logic val,
                         input logic glitch, input logic exp_flag, input string tag);
    for (int e = 0; e < n; e++) begin
      edge_cnt    = EDGE_W'(e);
      par_chk_en  = is_par;
      stp_chk_en  = ~is_par;
      sampled_bit = (e == ps - 2 || !glitch) ? val : ~val;
      tick;
      if (e == ps - 2) chk(tag, 32'(is_par ? par_err : stp_err), 32'(exp_flag));
    end
  endtask

  task automatic start_frame(input int ps, input logic [7:0] data, input logic pen,
                             input logic ptyp, input logic s2);
    Prescale    = EDGE_W'(ps);
    P_DATA      = data;
    par_en      = pen;
    par_typ     = ptyp;
    stop2       = s2;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    par_en      = ~pen;
    par_typ     = ~ptyp;
    stop2       = ~s2;
    chk("start_pe_clr", 32'(par_err), 32'd0);
    chk("start_se_clr", 32'(stp_err), 32'd0);
    for (int e = 0; e < 2; e++) begin
      edge_cnt = EDGE_W'(e);
      tick;
    end
  endtask

  task automatic run_frame(input int ps, input logic [7:0] data, input logic pen, input logic ptyp,
                           input logic s2, input logic pbit, input logic sb1, input logic sb2,
                           input logic glitch, input logic clr_done);
    exp_t e;
    logic ep, es;
    ep = pen && (pbit != ((^data) ^ ptyp));
    es = !sb1 || (s2 && !sb2);
    e.vld = !ep && !es;
    e.pe  = ep;
    e.se  = es;
    exp_q.push_back(e);
    start_frame(ps, data, pen, ptyp, s2);
    if (pen) one_bit(ps, ps, 1'b1, pbit, glitch, ep, "par_at_chk");
    one_bit(ps, ps, 1'b0, sb1, glitch, !sb1, "stp1_at_chk");
    if (s2) one_bit(ps, ps, 1'b0, sb2, glitch, es, "stp2_at_chk");
    idle_in;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("done_vld", 32'(frame_vld), 32'(e.vld));
      chk("done_pe", 32'(par_err), 32'(e.pe));
      chk("done_se", 32'(stp_err), 32'(e.se));
    end
    err_clr = clr_done;
    tick;
    err_clr = 1'b0;
    if (clr_done) begin
      m_pcnt = 0; m_scnt = 0; m_pstk = 1'b0; m_sstk = 1'b0;
    end else begin
      if (ep && m_pcnt < 255) m_pcnt++;
      if (es && m_scnt < 255) m_scnt++;
      m_pstk = m_pstk | ep;
      m_sstk = m_sstk | es;
    end
    chk("vld_one_cycle", 32'(frame_vld), 32'd0);
    chk("pe_hold", 32'(par_err), 32'(ep));
    chk_status("post");
  endtask

  initial begin
    RST = 1'b0;
    Prescale = EDGE_W'(8);
    P_DATA = '0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    idle_in;
    tick; tick;
    chk("rst_pe", 32'(par_err), 32'd0);
    chk("rst_se", 32'(stp_err), 32'd0);
    chk("rst_vld", 32'(frame_vld), 32'd0);
    chk_status("rst");
    RST = 1'b1;
    tick;

    run_frame(8, 8'hA5, 1, 0, 0, 0, 1, 1, 0, 0);
    run_frame(8, 8'hA5, 1, 0, 0, 1, 1, 1, 0, 0);
    run_frame(8, 8'h3C, 1, 1, 0, 1, 1, 1, 0, 0);
    run_frame(8, 8'h3C, 1, 1, 0, 0, 1, 1, 0, 0);
    run_frame(8, 8'h5A, 1, 0, 1, 0, 1, 0, 0, 0);
    run_frame(8, 8'h5A, 1, 0, 1, 0, 0, 1, 0, 0);
    run_frame(8, 8'hFF, 0, 0, 0, 1, 1, 1, 0, 0);
    run_frame(16, 8'hC3, 1, 0, 0, 0, 1, 1, 1, 0);
    run_frame(32, 8'h81, 1, 1, 1, 1, 1, 1, 1, 0);
    run_frame(32, 8'h81, 0, 0, 0, 0, 1, 1, 1, 0);

    // RX FSM drops the stop enable mid-window: flag set, but no DONE.
    start_frame(8, 8'h11, 0, 0, 0);
    one_bit(8, 7, 1'b0, 1'b0, 1'b0, 1'b1, "drop_stp");
    idle_in;
    tick;
    chk("drop_vld", 32'(frame_vld), 32'd0);
    tick;
    chk_status("drop");

    // Restart during STP1 with a parity error already flagged.
    start_frame(8, 8'hA5, 1, 0, 0);
    one_bit(8, 8, 1'b1, 1'b1, 1'b0, 1'b1, "ab_par");
    one_bit(8, 3, 1'b0, 1'b1, 1'b0, 1'b0, "ab_unused");
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("ab_pe_clr", 32'(par_err), 32'd0);
    chk("ab_se_clr", 32'(stp_err), 32'd0);
    chk("ab_vld", 32'(frame_vld), 32'd0);
    chk_status("ab");
    one_bit(8, 7, 1'b0, 1'b0, 1'b0, 1'b1, "ab_stp");
    #2;
    RST = 1'b0;
    #1;
    m_pcnt = 0; m_scnt = 0; m_pstk = 1'b0; m_sstk = 1'b0;
    chk("mid_rst_se", 32'(stp_err), 32'd0);
    chk("mid_rst_pe", 32'(par_err), 32'd0);
    chk("mid_rst_vld", 32'(frame_vld), 32'd0);
    chk_status("mid_rst");
    idle_in;
    tick;
    RST = 1'b1;
    tick;
    run_frame(8, 8'hA5, 1, 0, 0, 0, 1, 1, 0, 0);

    for (int i = 0; i < 256; i++) run_frame(4, 8'(i), 0, 0, 0, 0, 0, 1, 0, 0);
    chk("sat_scnt", 32'(stp_err_cnt), 32'hFF);
    run_frame(4, 8'h00, 1, 0, 0, 1, 0, 1, 0, 1);
    chk("clr_scnt_zero", 32'(stp_err_cnt), 32'd0);
    run_frame(4, 8'h07, 1, 1, 0, 1, 0, 1, 0, 0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
